// File: rtl/dff.sv
// Resettable register with complemented output; one storage bit per data bit,
// all bits sharing clk/rst. qb is derived from q so the two can never disagree.
`timescale 1ns/1ps

module dff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Synchronous reset takes priority over d at the same edge
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(.RST_VAL(RST_VAL[i])) u_bit (
      .clk (clk),
      .rst (rst),
      .d   (d[i]),
      .q   (q[i])
    );
  end

  assign qb = ~q;

endmodule

// File: tb/tb_dff.sv
// Bench for dff: directed timeline on a 1-bit instance, reset/load on an 8-bit
// instance with RST_VAL=8'hA5, then randomized cycles against a next-value model.
`timescale 1ns/1ps

module tb_dff;

  localparam logic [7:0] WRST = 8'hA5;

  logic       clk;
  logic       rst,  d,  q,  qb;
  logic       rstw;
  logic [7:0] dw, qw, qbw;

  int passed = 0;
  int total  = 0;

  dff u_n (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .qb  (qb)
  );

  dff #(.WIDTH(8), .RST_VAL(WRST)) u_w (
    .clk (clk),
    .rst (rstw),
    .d   (dw),
    .q   (qw),
    .qb  (qbw)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // First edge at 50 ns with rst=0, d=0
  task automatic test_first_edge();
    @(posedge clk); #1;
    chk1("first_edge_q",  q,  1'b0);
    chk1("first_edge_qb", qb, 1'b1);
  endtask

  // d=1 before the 150 ns edge; q must not move until that edge
  task automatic test_latency();
    @(negedge clk); d = 1'b1;
    #40;
    chk1("latency_early_q", q, 1'b0);
    @(posedge clk); #1;
    chk1("latency_q",  q,  1'b1);
    chk1("latency_qb", qb, 1'b0);
  endtask

  // rst=1 with d=1 at 200 ns: no change until the 250 ns edge, then reset wins
  task automatic test_reset_override();
    @(negedge clk); rst = 1'b1; d = 1'b1;
    #1;
    chk1("rst_assert_noasync_q", q, 1'b1);
    @(posedge clk); #1;
    chk1("rst_override_q",  q,  1'b0);
    chk1("rst_override_qb", qb, 1'b1);
  endtask

  // Release at 300 ns; the 350 ns edge loads d directly
  task automatic test_recovery();
    @(negedge clk); rst = 1'b0; d = 1'b1;
    @(posedge clk); #1;
    chk1("recovery_q",  q,  1'b1);
    chk1("recovery_qb", qb, 1'b0);
  endtask

  // Pulses on d and rst inside the high phase must not reach q; falling edge is inert
  task automatic test_glitch();
    logic held;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); d = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      held = q;
      #20 d = ~d;
      #10 rst = 1'b1;
      #10 rst = 1'b0; d = ~d;
      #8;
      chk1("glitch_hold_q",  q,  held);
      chk1("glitch_hold_qb", qb, ~held);
      @(negedge clk); #1;
      chk1("negedge_hold_q", q,  held);
      chk1("negedge_qb_inv", qb, ~q);
    end
  endtask

  task automatic test_wide_reset();
    @(negedge clk); rstw = 1'b1; dw = 8'hFF;
    @(posedge clk); #1;
    chk8("wide_rst_q",  qw,  8'hA5);
    chk8("wide_rst_qb", qbw, 8'h5A);
    @(negedge clk); rstw = 1'b0; dw = 8'h3C;
    @(posedge clk); #1;
    chk8("wide_load_q",  qw,  8'h3C);
    chk8("wide_load_qb", qbw, 8'hC3);
  endtask

  // rst held over several edges keeps RST_VAL whatever d does
  task automatic test_wide_hold_reset();
    @(negedge clk); rstw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dw = 8'($urandom);
      @(posedge clk); #1;
      chk8("wide_hold_rst_q",  qw,  WRST);
      chk8("wide_hold_rst_qb", qbw, ~WRST);
      @(negedge clk);
    end
    rstw = 1'b0;
  endtask

  // Random rst/d on both instances; expected next q is RST_VAL under rst, else d
  task automatic test_random();
    logic       en;
    logic [7:0] ew;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 3) == 0);
      d    = 1'($urandom_range(0, 1));
      rstw = ($urandom_range(0, 3) == 0);
      dw   = 8'($urandom);
      en   = rst  ? 1'b0 : d;
      ew   = rstw ? WRST : dw;
      @(posedge clk); #1;
      chk1("rand_q",   q,   en);
      chk1("rand_qb",  qb,  ~en);
      chk8("rand_qw",  qw,  ew);
      chk8("rand_qbw", qbw, ~ew);
    end
  endtask

  initial begin
    rst = 1'b0; d = 1'b0; rstw = 1'b0; dw = 8'h00;
    test_first_edge();
    test_latency();
    test_reset_override();
    test_recovery();
    test_glitch();
    test_wide_reset();
    test_wide_hold_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter: WIDTH, default 1, data path width in bits for d, q and qb.
REQ-002 Parameter: RST_VAL, default all-zeros (WIDTH bits), value loaded into q on reset.
REQ-003 Port: clk  input  1  sole clock; all state updates occur on the rising edge only.
REQ-004 Port: rst  input  1  reset, synchronous and active-high; sampled on rising clk edge.
REQ-005 Port: d  input  WIDTH  data input, sampled on rising clk edge.
REQ-006 Port: q  output  WIDTH  registered data output.
REQ-007 Port: qb  output  WIDTH  bitwise complement of q.
REQ-008 One clock domain, clk; reset is synchronous and active-high, port named rst.

Function
REQ-009 On each rising clk edge with rst=0, q SHALL take the value of d present at that edge.
REQ-010 Latency d -> q SHALL be exactly one clock edge; no combinational path from d to q or qb.
REQ-011 qb SHALL equal ~q at all times, bit for bit, including during and after reset; no independent storage for qb.
REQ-012 Between rising edges, q SHALL hold its value regardless of changes on d or rst.
REQ-013 Falling clk edges SHALL have no effect on q or qb.
REQ-014 Simultaneous rst=1 and any d at a rising edge: reset SHALL win; q <= RST_VAL, d is ignored.
REQ-015 Assertion of rst between edges SHALL NOT change q until the next rising edge (no asynchronous path).
REQ-016 Deassertion of rst: the first rising edge with rst=0 SHALL load d normally; no extra recovery cycle.
REQ-017 Each bit SHALL behave independently for WIDTH>1; all bits update on the same edge.
REQ-018 No enable, no scan or set inputs; the block SHALL be purely a reset-able register with complemented output.

Reset
REQ-019 Reset value: q = RST_VAL, qb = ~RST_VAL, established at the first rising edge with rst=1.
REQ-020 Before the first rising edge, q is undefined (X in simulation); benches SHALL NOT check q before the first edge.
REQ-021 rst held high for N edges SHALL keep q = RST_VAL for all N edges.

Verification
REQ-022 Clock period 100 ns (50/50); rst=0, d=0 for first edge -> q=0, qb=1 after edge at 50 ns.
REQ-023 rst=0, d=1 at next edge (150 ns) -> q=1, qb=0 one edge later, not before.
REQ-024 rst=1, d=1 at edge 250 ns -> q=0, qb=1 (reset overrides d); q unchanged at rst assertion time 200 ns.
REQ-025 rst=0, d=1 at edge 350 ns -> q=1, qb=0 (immediate recovery, no extra cycle).
REQ-026 Toggle d between edges (glitch pulse not spanning an edge) -> q unchanged; check qb==~q on every cycle.
REQ-027 WIDTH=8, RST_VAL=8'hA5: rst=1 one edge -> q=8'hA5, qb=8'h5A; then d=8'h3C, rst=0 -> q=8'h3C, qb=8'hC3.
